// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter and the memory it fronts:
// default bus widths, arbiter state encoding and requester identifiers.
// ----------------------------------------------------------------------------
package dmem_pkg;

  // Default widths, shared with the single-port data memory.
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 8;

  // Arbiter state: free arbitration, or ownership held by one requester.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_C = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

  // Requester identifiers, used for the last-winner record.
  localparam logic REQ_C = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester handshakes (core C, DMA D) and the memory-side bus.
//   c_* / d_* : req, we, lock, addr, wdata in; gnt, rvalid, rdata out
//   mem_*     : addr, wdata, we out to memory; rdata in (combinational)
// Modport slave is taken by the arbiter; modport master by the requesters
// and memory model that surround it.
// ----------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int ADDR_WIDTH = DMEM_ADDR_W
);

  logic                  c_req_i;
  logic                  c_we_i;
  logic                  c_lock_i;
  logic [ADDR_WIDTH-1:0] c_addr_i;
  logic [DATA_WIDTH-1:0] c_wdata_i;
  logic                  c_gnt_o;
  logic                  c_rvalid_o;
  logic [DATA_WIDTH-1:0] c_rdata_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic                  d_lock_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  c_req_i, c_we_i, c_lock_i, c_addr_i, c_wdata_i,
    input  d_req_i, d_we_i, d_lock_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output c_gnt_o, c_rvalid_o, c_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_we_o
  );

  modport master (
    output c_req_i, c_we_i, c_lock_i, c_addr_i, c_wdata_i,
    output d_req_i, d_we_i, d_lock_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  c_gnt_o, c_rvalid_o, c_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// ----------------------------------------------------------------------------
// dmem_rr_pick
// Combinational two-way round-robin picker.
//   i_req_c, i_req_d   : requests
//   i_last_winner      : REQ_C / REQ_D, who won the previous grant
//   i_force_c/d        : owner of an unexpired lock; wins if it requests
//   o_gnt_c, o_gnt_d   : one-hot (or zero) grant
// ----------------------------------------------------------------------------
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic i_req_c,
  input  logic i_req_d,
  input  logic i_last_winner,
  input  logic i_force_c,
  input  logic i_force_d,
  output logic o_gnt_c,
  output logic o_gnt_d
);

  always_comb begin
    o_gnt_c = 1'b0;
    o_gnt_d = 1'b0;
    if (i_force_c) begin
      o_gnt_c = i_req_c;
    end else if (i_force_d) begin
      o_gnt_d = i_req_d;
    end else if (i_req_c && i_req_d) begin
      // Conflict: the side that did not win last time goes now.
      if (i_last_winner == REQ_D) o_gnt_c = 1'b1;
      else                        o_gnt_d = 1'b1;
    end else begin
      o_gnt_c = i_req_c;
      o_gnt_d = i_req_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the core LSU (C) and the DMA
// engine (D): one access per cycle, round-robin on conflicts, and a bounded
// lock so a requester can keep ownership for read-modify-write sequences.
// Read data is registered and returned with a one-cycle rvalid pulse.
//   clock : rising-edge system clock
//   reset : asynchronous, active-low
//   bus   : dmem_arbiter_if.slave (requester handshakes + memory bus)
// ----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int ADDR_WIDTH = DMEM_ADDR_W,
  parameter int LOCK_MAX   = 4
)(
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  arb_state_e            r_state;
  logic                  r_last_winner;
  logic [CNT_W-1:0]      r_lock_cnt;

  logic                  r_c_rvalid;
  logic [DATA_WIDTH-1:0] r_c_rdata;
  logic                  r_d_rvalid;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic                  w_lock_c;
  logic                  w_lock_d;
  logic                  w_hold_c;
  logic                  w_hold_d;
  logic                  w_hold;
  logic                  w_broken;
  logic                  w_pick_last;
  logic                  w_pick_c;
  logic                  w_pick_d;
  logic                  w_gnt_c;
  logic                  w_gnt_d;
  logic                  w_win;
  logic                  w_win_lock;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_mem_we;

  assign w_lock_c = (r_state == LOCK_C);
  assign w_lock_d = (r_state == LOCK_D);

  // Owner keeps priority only while it requests and the lock is unexpired.
  assign w_hold_c = w_lock_c && bus.c_req_i && (r_lock_cnt < CNT_MAX);
  assign w_hold_d = w_lock_d && bus.d_req_i && (r_lock_cnt < CNT_MAX);
  assign w_hold   = w_hold_c || w_hold_d;

  // Expired lock with the owner still requesting: the owner is treated as
  // the last winner so the other side gets its turn.
  assign w_broken = ((w_lock_c && bus.c_req_i) || (w_lock_d && bus.d_req_i)) &&
                    (r_lock_cnt >= CNT_MAX);

  always_comb begin
    w_pick_last = r_last_winner;
    if (w_broken) w_pick_last = w_lock_d ? REQ_D : REQ_C;
  end

  dmem_rr_pick u_pick (
    .i_req_c       (bus.c_req_i),
    .i_req_d       (bus.d_req_i),
    .i_last_winner (w_pick_last),
    .i_force_c     (w_hold_c),
    .i_force_d     (w_hold_d),
    .o_gnt_c       (w_pick_c),
    .o_gnt_d       (w_pick_d)
  );

  // Reset kills grants combinationally so nothing reaches memory while low.
  assign w_gnt_c    = w_pick_c && reset;
  assign w_gnt_d    = w_pick_d && reset;
  assign w_win      = w_gnt_c || w_gnt_d;
  assign w_win_lock = w_gnt_c ? bus.c_lock_i : bus.d_lock_i;

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    if (w_gnt_c) begin
      w_mem_addr  = bus.c_addr_i;
      w_mem_wdata = bus.c_wdata_i;
      w_mem_we    = bus.c_we_i;
    end else if (w_gnt_d) begin
      w_mem_addr  = bus.d_addr_i;
      w_mem_wdata = bus.d_wdata_i;
      w_mem_we    = bus.d_we_i;
    end
  end

  // Lock FSM and last-winner record.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_lock_cnt    <= '0;
      r_last_winner <= REQ_D;
    end else if (w_win) begin
      r_last_winner <= w_gnt_d ? REQ_D : REQ_C;
      if (w_hold) begin
        if (w_win_lock) begin
          r_lock_cnt <= r_lock_cnt + CNT_ONE;
        end else begin
          r_state    <= IDLE;
          r_lock_cnt <= '0;
        end
      end else if (!w_broken && w_win_lock) begin
        r_state    <= w_gnt_c ? LOCK_C : LOCK_D;
        r_lock_cnt <= CNT_ONE;
      end else begin
        r_state    <= IDLE;
        r_lock_cnt <= '0;
      end
    end else begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
    end
  end

  // Read return: capture memory data at the edge ending a granted read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_c_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_c_rvalid <= w_gnt_c && !bus.c_we_i;
      r_d_rvalid <= w_gnt_d && !bus.d_we_i;
      if (w_gnt_c && !bus.c_we_i) r_c_rdata <= bus.mem_rdata_i;
      if (w_gnt_d && !bus.d_we_i) r_d_rdata <= bus.mem_rdata_i;
    end
  end

  assign bus.c_gnt_o     = w_gnt_c;
  assign bus.d_gnt_o     = w_gnt_d;
  assign bus.c_rvalid_o  = r_c_rvalid;
  assign bus.c_rdata_o   = r_c_rdata;
  assign bus.d_rvalid_o  = r_d_rvalid;
  assign bus.d_rdata_o   = r_d_rdata;
  assign bus.mem_addr_o  = w_mem_addr;
  assign bus.mem_wdata_o = w_mem_wdata;
  assign bus.mem_we_o    = w_mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios plus a randomized run against a behavioural model of
// the arbitration rules (lock owner, locked-grant run length, last winner)
// and a shadow copy of memory contents.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int LM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LOCK_MAX(LM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory environment: combinational read, synchronous write, plus a
  // preload port used only while no requester is active.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        pl_we   = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign bus.mem_rdata_i = mem[bus.mem_addr_o];

  always @(posedge clock) begin
    if (pl_we)             mem[pl_addr]        <= pl_data;
    else if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model state: 0 = no lock owner, 1 = C owns, 2 = D owns.
  int m_owner;
  int m_run;
  bit m_last;   // 0 = C won last, 1 = D won last

  task automatic idle_inputs();
    bus.c_req_i = 1'b0; bus.c_we_i = 1'b0; bus.c_lock_i = 1'b0;
    bus.c_addr_i = 8'h0; bus.c_wdata_i = 32'h0;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_lock_i = 1'b0;
    bus.d_addr_i = 8'h0; bus.d_wdata_i = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    ref_mem[a] = d;
    @(posedge clock);
    #1 pl_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.c_req_i = 1'b1; bus.d_req_i = 1'b1; bus.d_we_i = 1'b1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_c_gnt got %b want 0", bus.c_gnt_o); end
    checks++; if (bus.d_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got %b want 0", bus.d_gnt_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we_o); end
    checks++; if (bus.c_rvalid_o !== 1'b0 || bus.d_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b want 00", bus.c_rvalid_o, bus.d_rvalid_o); end
    checks++; if (bus.c_rdata_o !== 32'h0 || bus.d_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0", bus.c_rdata_o, bus.d_rdata_o); end
    do_reset();
  endtask

  task automatic test_single_read();
    preload(8'h10, 32'hDEADBEEF);
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b0; bus.c_addr_i = 8'h10;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin errors++; $display("FAIL rd_gnt got c%b d%b want c1 d0", bus.c_gnt_o, bus.d_gnt_o); end
    checks++; if (bus.mem_addr_o !== 8'h10 || bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rd_mem got a%h we%b want a10 we0", bus.mem_addr_o, bus.mem_we_o); end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    checks++; if (bus.c_rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b want 1", bus.c_rvalid_o); end
    checks++; if (bus.c_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", bus.c_rdata_o); end
    checks++; if (bus.d_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_d_rvalid got %b want 0", bus.d_rvalid_o); end
    @(negedge clock);
    checks++; if (bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_pulse_end got %b want 0", bus.c_rvalid_o); end
    checks++; if (bus.c_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %h want deadbeef", bus.c_rdata_o); end
    @(posedge clock); #1;
  endtask

  task automatic test_alternate();
    do_reset();
    bus.c_req_i = 1'b1; bus.c_addr_i = 8'h10;
    bus.d_req_i = 1'b1; bus.d_addr_i = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (bus.c_gnt_o !== ((i % 2) == 0) || bus.d_gnt_o !== ((i % 2) == 1)) begin
        errors++; $display("FAIL alt_gnt[%0d] got c%b d%b want c%b d%b", i, bus.c_gnt_o, bus.d_gnt_o, (i % 2) == 0, (i % 2) == 1);
      end
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_write_then_read();
    do_reset();
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b1; bus.c_addr_i = 8'h20; bus.c_wdata_i = 32'h12345678;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 8'h20;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin errors++; $display("FAIL wr_gnt got c%b d%b want c1 d0", bus.c_gnt_o, bus.d_gnt_o); end
    checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 8'h20 || bus.mem_wdata_o !== 32'h12345678) begin
      errors++; $display("FAIL wr_mem got we%b a%h d%h want we1 a20 d12345678", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); end
    ref_mem[8'h20] = 32'h12345678;
    @(posedge clock); #1 bus.c_req_i = 1'b0; bus.c_we_i = 1'b0;
    @(negedge clock);
    checks++; if (bus.d_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_d_gnt got %b want 1", bus.d_gnt_o); end
    checks++; if (bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", bus.c_rvalid_o); end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    checks++; if (bus.d_rvalid_o !== 1'b1 || bus.d_rdata_o !== 32'h12345678) begin
      errors++; $display("FAIL wr_d_rdata got v%b %h want v1 12345678", bus.d_rvalid_o, bus.d_rdata_o); end
    @(posedge clock); #1;
  endtask

  task automatic test_lock();
    do_reset();
    bus.c_req_i = 1'b1; bus.c_lock_i = 1'b1; bus.c_addr_i = 8'h30;
    bus.d_req_i = 1'b1; bus.d_addr_i = 8'h31;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (bus.c_gnt_o !== (i < LM) || bus.d_gnt_o !== (i >= LM)) begin
        errors++; $display("FAIL lock_gnt[%0d] got c%b d%b want c%b d%b", i, bus.c_gnt_o, bus.d_gnt_o, i < LM, i >= LM);
      end
      @(posedge clock); #1;
    end
    // Back to plain round-robin: C then D.
    bus.c_lock_i = 1'b0;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin errors++; $display("FAIL lock_after1 got c%b d%b want c1 d0", bus.c_gnt_o, bus.d_gnt_o); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b0 || bus.d_gnt_o !== 1'b1) begin errors++; $display("FAIL lock_after2 got c%b d%b want c0 d1", bus.c_gnt_o, bus.d_gnt_o); end
    @(posedge clock); #1 idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.c_req_i = 1'b1; bus.c_addr_i = 8'h10;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt got %b want 1", bus.c_gnt_o); end
    @(posedge clock);
    reset = 1'b0;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 8'h40; bus.d_wdata_i = 32'hA5A5A5A5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++; if (bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid[%0d] got %b want 0", i, bus.c_rvalid_o); end
      checks++; if (bus.c_gnt_o !== 1'b0 || bus.d_gnt_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin
        errors++; $display("FAIL rst_mid_gnt0[%0d] got c%b d%b we%b want 000", i, bus.c_gnt_o, bus.d_gnt_o, bus.mem_we_o); end
    end
    @(posedge clock); #1 reset = 1'b1; bus.d_we_i = 1'b0;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_mid_first got c%b d%b want c1 d0", bus.c_gnt_o, bus.d_gnt_o); end
    @(posedge clock); #1 idle_inputs();
  endtask

  task automatic test_lock_drop();
    do_reset();
    bus.c_req_i = 1'b1; bus.c_lock_i = 1'b1; bus.c_addr_i = 8'h50;
    bus.d_req_i = 1'b1; bus.d_addr_i = 8'h51;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin errors++; $display("FAIL drop_c got c%b d%b want c1 d0", bus.c_gnt_o, bus.d_gnt_o); end
    @(posedge clock); #1 bus.c_req_i = 1'b0; bus.c_lock_i = 1'b0;
    @(negedge clock);
    checks++; if (bus.c_gnt_o !== 1'b0 || bus.d_gnt_o !== 1'b1) begin errors++; $display("FAIL drop_d got c%b d%b want c0 d1", bus.c_gnt_o, bus.d_gnt_o); end
    @(posedge clock); #1 idle_inputs();
  endtask

  task automatic test_random();
    bit          gc, gd, hc, hd, brk, wl, c_done, d_done;
    bit          exp_c_rv, exp_d_rv;
    logic [31:0] exp_c_rd, exp_d_rd, exp_wd;
    logic [7:0]  exp_a;
    bit          exp_we;
    do_reset();
    m_owner = 0; m_run = 0; m_last = 1'b1;
    exp_c_rv = 1'b0; exp_d_rv = 1'b0; exp_c_rd = 32'h0; exp_d_rd = 32'h0;
    for (int a = 0; a < 16; a++) preload(8'(a * 17), $urandom);
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!bus.c_req_i && $urandom_range(0, 2) != 0) begin
        bus.c_req_i = 1'b1; bus.c_we_i = 1'($urandom_range(0, 1));
        bus.c_addr_i = 8'($urandom_range(0, 15) * 17); bus.c_wdata_i = $urandom;
      end
      if (!bus.d_req_i && $urandom_range(0, 2) != 0) begin
        bus.d_req_i = 1'b1; bus.d_we_i = 1'($urandom_range(0, 1));
        bus.d_addr_i = 8'($urandom_range(0, 15) * 17); bus.d_wdata_i = $urandom;
      end
      bus.c_lock_i = ($urandom_range(0, 3) != 0);
      bus.d_lock_i = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      // Who should win this cycle.
      hc = (m_owner == 1) && bus.c_req_i && (m_run < LM);
      hd = (m_owner == 2) && bus.d_req_i && (m_run < LM);
      if (hc)      begin gc = 1'b1; gd = 1'b0; end
      else if (hd) begin gc = 1'b0; gd = 1'b1; end
      else if (bus.c_req_i && bus.d_req_i) begin gc = m_last; gd = !m_last; end
      else begin gc = bus.c_req_i; gd = bus.d_req_i; end
      exp_a  = gc ? bus.c_addr_i  : (gd ? bus.d_addr_i  : 8'h0);
      exp_wd = gc ? bus.c_wdata_i : (gd ? bus.d_wdata_i : 32'h0);
      exp_we = gc ? bus.c_we_i    : (gd ? bus.d_we_i    : 1'b0);
      checks++; if (bus.c_gnt_o !== gc || bus.d_gnt_o !== gd) begin
        errors++; $display("FAIL rnd_gnt[%0d] got c%b d%b want c%b d%b", cyc, bus.c_gnt_o, bus.d_gnt_o, gc, gd); end
      checks++; if (bus.mem_addr_o !== exp_a || bus.mem_we_o !== exp_we || bus.mem_wdata_o !== exp_wd) begin
        errors++; $display("FAIL rnd_mem[%0d] got a%h we%b d%h want a%h we%b d%h", cyc, bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, exp_a, exp_we, exp_wd); end
      checks++; if (bus.c_rvalid_o !== exp_c_rv || bus.c_rdata_o !== exp_c_rd) begin
        errors++; $display("FAIL rnd_c_rd[%0d] got v%b %h want v%b %h", cyc, bus.c_rvalid_o, bus.c_rdata_o, exp_c_rv, exp_c_rd); end
      checks++; if (bus.d_rvalid_o !== exp_d_rv || bus.d_rdata_o !== exp_d_rd) begin
        errors++; $display("FAIL rnd_d_rd[%0d] got v%b %h want v%b %h", cyc, bus.d_rvalid_o, bus.d_rdata_o, exp_d_rv, exp_d_rd); end
      // What the coming edge does.
      exp_c_rv = gc && !bus.c_we_i;
      exp_d_rv = gd && !bus.d_we_i;
      if (exp_c_rv) exp_c_rd = ref_mem[bus.c_addr_i];
      if (exp_d_rv) exp_d_rd = ref_mem[bus.d_addr_i];
      if (gc && bus.c_we_i) ref_mem[bus.c_addr_i] = bus.c_wdata_i;
      if (gd && bus.d_we_i) ref_mem[bus.d_addr_i] = bus.d_wdata_i;
      brk = (((m_owner == 1) && bus.c_req_i) || ((m_owner == 2) && bus.d_req_i)) && (m_run >= LM);
      wl  = gc ? bus.c_lock_i : bus.d_lock_i;
      if (gc || gd) m_last = gd;
      if (hc || hd) begin
        if (wl) m_run++;
        else begin m_owner = 0; m_run = 0; end
      end else if (!brk && (gc || gd) && wl) begin
        m_owner = gc ? 1 : 2; m_run = 1;
      end else begin
        m_owner = 0; m_run = 0;
      end
      c_done = gc; d_done = gd;
      @(posedge clock); #1;
      if (c_done) bus.c_req_i = 1'b0;
      if (d_done) bus.d_req_i = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_write_then_read();
    test_lock();
    test_reset_mid();
    test_lock_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory (32-bit data, 8-bit word address, synchronous write, combinational read).
- Shares the memory between the core load/store unit (requester C) and the DMA engine (requester D).
- Performs at most one access per cycle, with round-robin fairness and a bounded lock for read-modify-write sequences.
- Registers read data and returns it with a one-cycle valid pulse to the winning requester.

Parameters:
- DATA_WIDTH, 32, data word width; must match the memory.
- ADDR_WIDTH, 8, word address width; must match the memory.
- LOCK_MAX, 4, maximum consecutive locked grants before the lock is forcibly broken; must be at least 1.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- c_req_i  in  1  core access request.
- c_we_i  in  1  core write enable; 1 = write, 0 = read.
- c_lock_i  in  1  core requests to keep ownership for the next access.
- c_addr_i  in  ADDR_WIDTH  core address.
- c_wdata_i  in  DATA_WIDTH  core write data.
- c_gnt_o  out  1  core grant; the transfer completes at the rising edge where c_req_i and c_gnt_o are both 1.
- c_rvalid_o  out  1  core read data valid, a one-cycle pulse.
- c_rdata_o  out  DATA_WIDTH  core read data.
- d_req_i, d_we_i, d_lock_i, d_addr_i, d_wdata_i, d_gnt_o, d_rvalid_o, d_rdata_o: DMA equivalents, same widths and meanings.
- mem_addr_o  out  ADDR_WIDTH  address to the memory.
- mem_wdata_o  out  DATA_WIDTH  write data to the memory.
- mem_we_o  out  1  write enable to the memory.
- mem_rdata_i  in  DATA_WIDTH  combinational read data from the memory.

Behaviour:
- Handshake
  - A requester holds req, we, addr and wdata stable from request until the cycle it is granted.
  - gnt is combinational from the request inputs and registered state.
  - At most one gnt is high per cycle; gnt is never high without the matching req.
- Memory side
  - mem_* outputs are a combinational mux of the winner's signals.
  - With no winner: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - A write commits at the rising edge that ends the grant cycle.
- Read return
  - On a granted read, mem_rdata_i is registered into x_rdata_o at the ending edge, and x_rvalid_o pulses high for exactly the next cycle.
  - Read latency: grant cycle N, data valid cycle N+1.
  - x_rdata_o holds its value until the next read to that requester.
  - Writes produce no rvalid.
  - Back-to-back reads each produce a pulse, so rvalid may stay high on consecutive cycles.
- Arbitration state
  - Registers: last_winner (reset = D, so C wins the first conflict); state IDLE / LOCK_C / LOCK_D; lock_cnt, sized to hold LOCK_MAX.
- IDLE
  - Only one requester active: it wins.
  - Both active: the requester other than last_winner wins.
  - The winner updates last_winner.
  - If the winner's lock_i=1 during its grant: go to LOCK_x and set lock_cnt=1.
- LOCK_x
  - If x requests and lock_cnt<LOCK_MAX: x wins regardless of the other requester. If lock_i is still 1, increment lock_cnt and stay; otherwise return to IDLE.
  - If x requests and lock_cnt==LOCK_MAX: the lock is broken. Arbitrate as in IDLE treating last_winner=x, so the other requester wins if it requests. Return to IDLE without entering LOCK on this grant, even if lock_i=1.
  - If x does not request: go to IDLE and arbitrate as IDLE in that same cycle.
- Simultaneous read and write from different requesters: impossible, because only one is granted per cycle.
- Reset assertion, including mid-operation
  - Immediately forces all gnt=0 and mem_we_o=0, independent of inputs.
  - Clears x_rvalid_o=0, x_rdata_o=0, state=IDLE, lock_cnt=0, last_winner=D.
  - A pending read response is discarded.
- Address wrap is not applicable: addresses are passed through unmodified.

Decomposition:
- Shared package dmem_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults, shared with the memory.
  - The arbiter state encoding (IDLE=2'd0, LOCK_C=2'd1, LOCK_D=2'd2).
  - Requester id constants REQ_C=1'b0 and REQ_D=1'b1.
- One sub-module, dmem_rr_pick: a combinational two-way round-robin picker (req_c, req_d, last_winner, force -> gnt_c, gnt_d).
- Lock FSM, mux and read-return registers stay in the top module.

Test Plan:
- C read addr 8'h10 (memory holds 32'hDEADBEEF), D idle -> c_gnt_o=1 in cycle N; c_rvalid_o=1 and c_rdata_o=32'hDEADBEEF in N+1; d_rvalid_o stays 0.
- C and D both request continuously from reset -> grants alternate C,D,C,D; no cycle has both gnt high.
- C writes 32'h12345678 to 8'h20 while D waits, then D reads 8'h20 -> D rdata=32'h12345678 one cycle after its grant.
- C holds lock_i=1 and req with LOCK_MAX=4 while D requests -> C granted 4 consecutive cycles, D granted on cycle 5; the FSM returns to IDLE.
- Reset pulled low in the cycle after a granted read -> rvalid never pulses, all gnt=0 during reset; after release, the first conflict is won by C.
- C lock_i=1 for one grant, then C drops req while D requests -> D granted the same cycle C drops req.
